branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Registered, parametrised branch resolution stage for the DRAC execute pipe.
//  - Evaluates conditional branches, JAL and JALR against the frontend prediction.
//  - Raises a mispredict/redirect, maintains a return-address stack (RAS) and
//    produces the link write-back.
//  - Sits between the register read stage and the commit/redirect logic, with one
//    valid/ready slot.
// PARAMETERS
//  ADDR_W     40  PC / target width in bits
//  DATA_W     64  operand width; ADDR_W <= DATA_W
//  INST_W     32  instruction width
//  RAS_DEPTH  8   return-address stack entries, power of two, >= 2
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          synchronous reset, active-high
//  valid_i          in   1          input instruction valid
//  ready_o          out  1          unit can accept an input this cycle
//  pc_i             in   ADDR_W     instruction PC
//  control_i        in   16         decode control: [4]=branch; [3]&[5]=jump; [0]=1 selects JALR
//  inst_i           in   INST_W     raw instruction (funct3, rd, rs1, immediates)
//  source1_i        in   DATA_W     rs1 value
//  source2_i        in   DATA_W     rs2 value
//  pred_taken_i     in   1          frontend predicted taken
//  pred_target_i    in   ADDR_W     frontend predicted target
//  flush_i          in   1          kill the held result and any input accepted this cycle
//  valid_o          out  1          result slot valid
//  ready_i          in   1          consumer accepts the result
//  branch_valid_o   out  1          result is a branch/JAL/JALR
//  branch_taken_o   out  1          resolved direction
//  branch_target_o  out  ADDR_W     resolved target
//  branch_result_o  out  ADDR_W     next PC: target if taken, else pc+4
//  mispredict_o     out  1          redirect required; qualified by valid_o
//  write_reg_o      out  5          link rd for JAL/JALR, else 0
//  write_data_o     out  DATA_W     pc+4, zero-extended
//  ras_top_o        out  ADDR_W     current RAS top (prediction for returns)
//  ras_valid_o      out  1          RAS holds at least one entry
// BEHAVIOUR
//  Reset:
//  - All outputs go to 0; RAS count = 0; pointer = 0.
//  - Reset mid-transfer drops the held result without a handshake.
//  Handshake and latency:
//  - ready_o = ~valid_o | ready_i.
//  - An input is accepted when valid_i & ready_o; results appear the next cycle (latency 1).
//  - A result is held stable while valid_o & ~ready_i.
//  - Full throughput is one instruction per cycle.
//  Flush:
//  - flush_i clears valid_o next cycle.
//  - An input accepted in the same cycle is discarded and does not touch the RAS.
//  - flush_i has priority over accept and ready_i.
//  Decode:
//  - jal = ~c[0]&c[3]&c[5].
//  - jalr = c[0]&c[3]&c[5]&(funct3==0).
//  - branch = c[4].
//  - Any other input is a non-branch: taken=0, mispredict=0, write_reg_o=0.
//  Conditions (funct3):
//  - 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu.
//  - funct3 010/011 give not taken.
//  Targets, all modulo 2^ADDR_W:
//  - B: pc + sext(B-imm).
//  - JAL: pc + sext(J-imm).
//  - JALR: (rs1 + sext(I-imm))[ADDR_W-1:0] with bit 0 cleared.
//  - pc+4 wraps at 2^ADDR_W.
//  Mispredict:
//  - mispredict_o = branch_valid & ((taken != pred_taken) | (taken & target != pred_target)).
//  - A not-taken branch predicted not-taken never mispredicts, whatever pred_target_i is.
//  RAS (updated at accept; link register = x1 or x5):
//  - Call: JAL/JALR with rd=link -> push pc+4.
//  - Return: JALR with rs1=link and rd!=link -> pop.
//  - JALR with rd=link and rs1=link, rd!=rs1 -> pop then push; net count unchanged, top replaced.
//  - JALR with rd=rs1=link -> push only.
//  - Push at full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
//  - Pop at empty: no change, no wrap; ras_valid_o stays 0.
//  - ras_top_o/ras_valid_o reflect RAS state after the previous cycle's update.
// TESTING
//  1. BEQ pc=0x100, imm=+16, rs1=rs2=5, pred_taken=0 -> next cycle valid_o=1, taken=1,
//     target=result=0x110, mispredict=1.
//  2. BLT rs1=-1, rs2=1, pred_taken=1, pred_target=0x90 at pc=0x80, imm=+16 -> taken=1,
//     target=0x90, mispredict=0; the same operands with BLTU -> taken=0, result=0x84, mispredict=1.
//  3. JALR rd=x0, rs1=x1, rs1=0x1003, imm=+2 -> target=0x1004 (bit 0 cleared), write_reg_o=0,
//     RAS pop; pc=0xFF_FFFF_FFFC JAL -> write_data_o=0 (wrap).
//  4. RAS: 9 calls (JAL rd=x1) at pc=0x0,0x10..0x80 with RAS_DEPTH=8 -> ras_top_o=0x84;
//     8 pops return 0x84..0x14, the oldest (0x4) is overwritten; 9th pop leaves ras_valid_o=0.
//  5. Back-pressure: ready_i=0 for 3 cycles with a result held -> outputs stable, ready_o=0,
//     input not accepted; ready_i=1 -> next input accepted the same cycle.
//  6. flush_i in the same cycle as an accepted call -> valid_o=0 next cycle, RAS count
//     unchanged; rst_i with a full RAS -> ras_valid_o=0 and all outputs 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Registered branch/JAL/JALR resolution with RAS and link write-back.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 64,
    parameter int INST_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [15:0]       control_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [DATA_W-1:0] source1_i,
    input  logic [DATA_W-1:0] source2_i,
    input  logic              pred_taken_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              branch_valid_o,
    output logic              branch_taken_o,
    output logic [ADDR_W-1:0] branch_target_o,
    output logic [ADDR_W-1:0] branch_result_o,
    output logic              mispredict_o,
    output logic [4:0]        write_reg_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic [ADDR_W-1:0] ras_top_o,
    output logic              ras_valid_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [2:0]        w_funct3;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_br;
    logic [ADDR_W-1:0] w_b_imm;
    logic [ADDR_W-1:0] w_j_imm;
    logic [ADDR_W-1:0] w_i_imm;
    logic [ADDR_W-1:0] w_jalr_sum;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic              w_cond;
    logic              w_bv;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_mp;
    logic              w_rd_link;
    logic              w_rs1_link;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_load;
    logic              w_unused;

    logic              valid_q, valid_d;
    logic              bv_q, bv_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] result_q, result_d;
    logic              mp_q, mp_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign w_unused = ^{control_i[15:6], control_i[2:1], inst_i[6:0]};

    assign w_funct3   = inst_i[14:12];
    assign w_rd       = inst_i[11:7];
    assign w_rs1      = inst_i[19:15];
    assign w_is_jal   = ~control_i[0] & control_i[3] & control_i[5];
    assign w_is_jalr  = control_i[0] & control_i[3] & control_i[5] & (w_funct3 == 3'b000);
    assign w_is_br    = control_i[4];
    assign w_b_imm    = {{(ADDR_W-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
    assign w_j_imm    = {{(ADDR_W-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
    assign w_i_imm    = {{(ADDR_W-12){inst_i[31]}}, inst_i[31:20]};
    // Only the low ADDR_W bits of rs1+imm matter, so the add is done at that width.
    assign w_jalr_sum = source1_i[ADDR_W-1:0] + w_i_imm;
    assign w_pc_plus4 = pc_i + ADDR_W'(4);

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = (source1_i == source2_i);
            3'b001:  w_cond = (source1_i != source2_i);
            3'b100:  w_cond = ($signed(source1_i) <  $signed(source2_i));
            3'b101:  w_cond = ($signed(source1_i) >= $signed(source2_i));
            3'b110:  w_cond = (source1_i <  source2_i);
            3'b111:  w_cond = (source1_i >= source2_i);
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_bv     = 1'b0;
        w_taken  = 1'b0;
        w_target = '0;
        if (w_is_jal) begin
            w_bv     = 1'b1;
            w_taken  = 1'b1;
            w_target = pc_i + w_j_imm;
        end else if (w_is_jalr) begin
            w_bv     = 1'b1;
            w_taken  = 1'b1;
            w_target = {w_jalr_sum[ADDR_W-1:1], 1'b0};
        end else if (w_is_br) begin
            w_bv     = 1'b1;
            w_taken  = w_cond;
            w_target = pc_i + w_b_imm;
        end
    end

    assign w_mp       = w_bv & ((w_taken != pred_taken_i) |
                                (w_taken & (w_target != pred_target_i)));
    assign w_rd_link  = (w_rd == 5'd1) | (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) | (w_rs1 == 5'd5);
    assign w_push     = (w_is_jal | w_is_jalr) & w_rd_link;
    assign w_pop      = w_is_jalr & w_rs1_link & (~w_rd_link | (w_rd != w_rs1));

    assign ready_o  = ~valid_q | ready_i;
    assign w_accept = valid_i & ready_o;
    assign w_load   = w_accept & ~flush_i;

    always_comb begin
        valid_d  = valid_q;
        bv_d     = bv_q;
        taken_d  = taken_q;
        target_d = target_q;
        result_d = result_q;
        mp_d     = mp_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
        if (w_load) begin
            bv_d     = w_bv;
            taken_d  = w_taken;
            target_d = w_target;
            result_d = w_taken ? w_target : w_pc_plus4;
            mp_d     = w_mp;
            wreg_d   = (w_is_jal | w_is_jalr) ? w_rd : 5'd0;
            wdata_d  = DATA_W'(w_pc_plus4);
        end
    end

    // ptr_q addresses the current top; a push at full wraps onto the oldest entry.
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (w_load) begin
            if (w_push && w_pop && (cnt_q != '0)) begin
                ras_d[ptr_q] = w_pc_plus4;
            end else if (w_push) begin
                ptr_d        = ptr_q + PTR_W'(1);
                ras_d[ptr_d] = w_pc_plus4;
                if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (w_pop && (cnt_q != '0)) begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            bv_q     <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            result_q <= '0;
            mp_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            bv_q     <= bv_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            result_q <= result_d;
            mp_q     <= mp_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ras_q    <= ras_d;
        end
    end

    assign valid_o         = valid_q;
    assign branch_valid_o  = bv_q;
    assign branch_taken_o  = taken_q;
    assign branch_target_o = target_q;
    assign branch_result_o = result_q;
    assign mispredict_o    = mp_q;
    assign write_reg_o     = wreg_q;
    assign write_data_o    = wdata_q;
    assign ras_valid_o     = (cnt_q != '0);
    assign ras_top_o       = (cnt_q != '0) ? ras_q[ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed scoreboard bench for branch_resolve_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam logic [15:0] C_BR   = 16'h0010;
    localparam logic [15:0] C_JAL  = 16'h0028;
    localparam logic [15:0] C_JALR = 16'h0029;

    typedef struct {
        logic              bv;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] result;
        logic              mp;
        logic [4:0]        wreg;
        logic [DATA_W-1:0] wdata;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [ADDR_W-1:0] pc_i = '0;
    logic [15:0]       control_i = '0;
    logic [31:0]       inst_i = '0;
    logic [DATA_W-1:0] source1_i = '0;
    logic [DATA_W-1:0] source2_i = '0;
    logic              pred_taken_i = 1'b0;
    logic [ADDR_W-1:0] pred_target_i = '0;
    logic              flush_i = 1'b0;
    logic              valid_o;
    logic              ready_i = 1'b1;
    logic              branch_valid_o;
    logic              branch_taken_o;
    logic [ADDR_W-1:0] branch_target_o;
    logic [ADDR_W-1:0] branch_result_o;
    logic              mispredict_o;
    logic [4:0]        write_reg_o;
    logic [DATA_W-1:0] write_data_o;
    logic [ADDR_W-1:0] ras_top_o;
    logic              ras_valid_o;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(32), .RAS_DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .control_i(control_i), .inst_i(inst_i),
        .source1_i(source1_i), .source2_i(source2_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .branch_valid_o(branch_valid_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .branch_result_o(branch_result_o), .mispredict_o(mispredict_o),
        .write_reg_o(write_reg_o), .write_data_o(write_data_o),
        .ras_top_o(ras_top_o), .ras_valid_o(ras_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic bv, input logic t, input logic [ADDR_W-1:0] tgt,
                                input logic [ADDR_W-1:0] res, input logic mp,
                                input logic [4:0] wr, input logic [DATA_W-1:0] wd);
        exp_t e;
        e.bv = bv; e.taken = t; e.target = tgt; e.result = res;
        e.mp = mp; e.wreg = wr; e.wdata = wd;
        return e;
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd3, 5'd2, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b1100111};
    endfunction

    // Called at a negedge; returns at the following negedge with valid_i dropped.
    task automatic issue(input logic [ADDR_W-1:0] pc, input logic [15:0] ctrl,
                         input logic [31:0] inst, input logic [DATA_W-1:0] s1,
                         input logic [DATA_W-1:0] s2, input logic pt,
                         input logic [ADDR_W-1:0] ptgt, input logic fl, input exp_t e);
        pc_i = pc; control_i = ctrl; inst_i = inst; source1_i = s1; source2_i = s2;
        pred_taken_i = pt; pred_target_i = ptgt; flush_i = fl; valid_i = 1'b1;
        #1;
        if (ready_o && !fl) sb.push_back(e);
        @(negedge clk_i);
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic check_ras(input string nm, input logic v, input logic [ADDR_W-1:0] top);
        chk({nm, "_ras_valid"}, 64'(ras_valid_o), 64'(v));
        chk({nm, "_ras_top"}, 64'(ras_top_o), 64'(top));
    endtask

    task automatic pop_ret();
        issue(40'h1000, C_JALR, enc_i(12'h0, 5'd1, 3'b000, 5'd0), 64'h2000, 64'h0, 1'b1,
              40'h2000, 1'b0, mk(1, 1, 40'h2000, 40'h2000, 0, 5'd0, 64'h1004));
    endtask

    task automatic call(input logic [ADDR_W-1:0] pc, input logic fl);
        issue(pc, C_JAL, enc_j(21'h100, 5'd1), 64'h0, 64'h0, 1'b1, pc + 40'h100, fl,
              mk(1, 1, pc + 40'h100, pc + 40'h100, 0, 5'd1, 64'(pc + 40'h4)));
    endtask

    // Monitor: consumes one expected result per output handshake.
    always @(negedge clk_i) begin
        #2;
        if (!rst_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got a result, expected none at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("branch_valid", 64'(branch_valid_o), 64'(mon_e.bv));
                chk("taken", 64'(branch_taken_o), 64'(mon_e.taken));
                chk("target", 64'(branch_target_o), 64'(mon_e.target));
                chk("result", 64'(branch_result_o), 64'(mon_e.result));
                chk("mispredict", 64'(mispredict_o), 64'(mon_e.mp));
                chk("write_reg", 64'(write_reg_o), 64'(mon_e.wreg));
                chk("write_data", write_data_o, mon_e.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        check_ras("rst", 1'b0, 40'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Conditional branches
        issue(40'h100, C_BR, enc_b(13'd16, 3'b000), 64'd5, 64'd5, 1'b0, 40'h0, 1'b0,
              mk(1, 1, 40'h110, 40'h110, 1, 5'd0, 64'h104));
        issue(40'h80, C_BR, enc_b(13'd16, 3'b100), '1, 64'd1, 1'b1, 40'h90, 1'b0,
              mk(1, 1, 40'h90, 40'h90, 0, 5'd0, 64'h84));
        issue(40'h80, C_BR, enc_b(13'd16, 3'b110), '1, 64'd1, 1'b1, 40'h90, 1'b0,
              mk(1, 0, 40'h90, 40'h84, 1, 5'd0, 64'h84));
        issue(40'h80, C_BR, enc_b(13'd16, 3'b101), '1, 64'd1, 1'b0, 40'hdead, 1'b0,
              mk(1, 0, 40'h90, 40'h84, 0, 5'd0, 64'h84));
        issue(40'h80, C_BR, enc_b(13'd16, 3'b111), '1, 64'd1, 1'b0, 40'h0, 1'b0,
              mk(1, 1, 40'h90, 40'h90, 1, 5'd0, 64'h84));
        issue(40'h80, C_BR, enc_b(13'd16, 3'b010), 64'd7, 64'd7, 1'b0, 40'h0, 1'b0,
              mk(1, 0, 40'h90, 40'h84, 0, 5'd0, 64'h84));
        issue(40'h100, C_BR, enc_b(13'h1FF0, 3'b000), 64'd9, 64'd9, 1'b1, 40'h100, 1'b0,
              mk(1, 1, 40'hF0, 40'hF0, 1, 5'd0, 64'h104));
        issue(40'h100, C_BR, enc_b(13'd16, 3'b001), 64'd5, 64'd5, 1'b0, 40'h1234, 1'b0,
              mk(1, 0, 40'h110, 40'h104, 0, 5'd0, 64'h104));

        // JALR / JAL / non-branch
        issue(40'h200, C_JALR, enc_i(12'd2, 5'd1, 3'b000, 5'd0), 64'h1003, 64'h0, 1'b1,
              40'h1004, 1'b0, mk(1, 1, 40'h1004, 40'h1004, 0, 5'd0, 64'h204));
        check_ras("pop_empty", 1'b0, 40'h0);
        issue(40'hFF_FFFF_FFFC, C_JAL, enc_j(21'd8, 5'd0), 64'h0, 64'h0, 1'b0, 40'h0, 1'b0,
              mk(1, 1, 40'h4, 40'h4, 1, 5'd0, 64'h0));
        issue(40'h40, C_JALR, enc_i(12'h0, 5'd2, 3'b001, 5'd1), 64'h0, 64'h0, 1'b1,
              40'h0, 1'b0, mk(0, 0, 40'h0, 40'h44, 0, 5'd0, 64'h44));
        check_ras("nonbranch", 1'b0, 40'h0);

        // RAS push / replace / pop combinations
        issue(40'h300, C_JAL, enc_j(21'h40, 5'd1), 64'h0, 64'h0, 1'b1, 40'h340, 1'b0,
              mk(1, 1, 40'h340, 40'h340, 0, 5'd1, 64'h304));
        check_ras("push1", 1'b1, 40'h304);
        issue(40'h400, C_JAL, enc_j(21'h40, 5'd5), 64'h0, 64'h0, 1'b1, 40'h440, 1'b0,
              mk(1, 1, 40'h440, 40'h440, 0, 5'd5, 64'h404));
        check_ras("push5", 1'b1, 40'h404);
        issue(40'h500, C_JALR, enc_i(12'h0, 5'd5, 3'b000, 5'd1), 64'h600, 64'h0, 1'b1,
              40'h600, 1'b0, mk(1, 1, 40'h600, 40'h600, 0, 5'd1, 64'h504));
        check_ras("poppush", 1'b1, 40'h504);
        issue(40'h600, C_JALR, enc_i(12'h0, 5'd1, 3'b000, 5'd0), 64'h304, 64'h0, 1'b1,
              40'h304, 1'b0, mk(1, 1, 40'h304, 40'h304, 0, 5'd0, 64'h604));
        check_ras("ret", 1'b1, 40'h304);
        issue(40'h700, C_JALR, enc_i(12'h0, 5'd1, 3'b000, 5'd1), 64'h800, 64'h0, 1'b1,
              40'h800, 1'b0, mk(1, 1, 40'h800, 40'h800, 0, 5'd1, 64'h704));
        check_ras("samelink", 1'b1, 40'h704);
        pop_ret();
        check_ras("ret2", 1'b1, 40'h304);
        pop_ret();
        check_ras("ret3", 1'b0, 40'h0);

        // RAS overflow and underflow
        for (int i = 0; i < 9; i++) call(40'(i * 16), 1'b0);
        check_ras("full", 1'b1, 40'h84);
        for (int k = 0; k < 8; k++) begin
            check_ras("unwind", 1'b1, 40'h84 - 40'(k * 16));
            pop_ret();
        end
        check_ras("drained", 1'b0, 40'h0);
        pop_ret();
        check_ras("underflow", 1'b0, 40'h0);

        // Back-pressure
        @(negedge clk_i);
        ready_i = 1'b0;
        issue(40'h100, C_BR, enc_b(13'd16, 3'b000), 64'd5, 64'd5, 1'b0, 40'h0, 1'b0,
              mk(1, 1, 40'h110, 40'h110, 1, 5'd0, 64'h104));
        pc_i = 40'h180; inst_i = enc_b(13'd16, 3'b001); source1_i = 64'd5; source2_i = 64'd6;
        pred_taken_i = 1'b1; pred_target_i = 40'h190; valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 64'(ready_o), 64'd0);
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_target", 64'(branch_target_o), 64'h110);
            chk("bp_wdata", write_data_o, 64'h104);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        issue(40'h180, C_BR, enc_b(13'd16, 3'b001), 64'd5, 64'd6, 1'b1, 40'h190, 1'b0,
              mk(1, 1, 40'h190, 40'h190, 0, 5'd0, 64'h184));
        @(negedge clk_i);

        // Flush of a held result, then flush of an accepted call
        ready_i = 1'b0;
        call(40'hA00, 1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_held_valid", 64'(valid_o), 64'd0);
        void'(sb.pop_back());
        check_ras("flush_held", 1'b1, 40'hA04);
        ready_i = 1'b1;
        pop_ret();
        call(40'h900, 1'b1);
        chk("flush_acc_valid", 64'(valid_o), 64'd0);
        check_ras("flush_acc", 1'b0, 40'h0);

        // Reset with a full RAS and a result held
        for (int i = 0; i < 8; i++) call(40'h2000 + 40'(i * 16), 1'b0);
        check_ras("prerst", 1'b1, 40'h2074);
        ready_i = 1'b0;
        call(40'h3000, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        #1;
        chk("rst2_valid", 64'(valid_o), 64'd0);
        chk("rst2_bv", 64'(branch_valid_o), 64'd0);
        chk("rst2_taken", 64'(branch_taken_o), 64'd0);
        chk("rst2_target", 64'(branch_target_o), 64'd0);
        chk("rst2_result", 64'(branch_result_o), 64'd0);
        chk("rst2_mp", 64'(mispredict_o), 64'd0);
        chk("rst2_wreg", 64'(write_reg_o), 64'd0);
        chk("rst2_wdata", write_data_o, 64'd0);
        chk("rst2_ready", 64'(ready_o), 64'd1);
        check_ras("rst2", 1'b0, 40'h0);
        ready_i = 1'b1;

        repeat (3) @(negedge clk_i);
        #3;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
